joypad_ctrl: RTL

- Input-conditioning stage directly upstream of the CPU's P1/JOYP register (0xFF00).
- Synchronises and debounces the eight raw active-low joypad pins.
- Holds the software-written P1 select bits and presents the multiplexed P1 read value to the memory map.
- Raises the joypad interrupt request on any high-to-low transition of the selected key lines.

---
 rtl/joypad_ctrl_if.sv | 10 +
 rtl/joypad_ctrl.sv | 96 +++++++++
 2 files changed

// File: rtl/joypad_ctrl_if.sv
// CPU-side P1/JOYP bus between the memory map and the joypad input stage.
interface joypad_ctrl_if;
  logic       p1_wr;
  logic [7:0] p1_wdata;
  logic [7:0] p1_rdata;
  logic       irq_joypad;

  modport master (output p1_wr, p1_wdata, input p1_rdata, irq_joypad);
  modport slave  (input p1_wr, p1_wdata, output p1_rdata, irq_joypad);
endinterface

// File: rtl/joypad_ctrl.sv
// Joypad input stage: synchronises and debounces the eight active-low pins,
// holds the P1 select bits, muxes the P1 read value and raises the joypad IRQ.
module joypad_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 20950,
  parameter int unsigned CNT_W           = 15
) (
  input  logic         cpu_clk,
  input  logic         rst,
  input  logic         joypad_up,
  input  logic         joypad_down,
  input  logic         joypad_left,
  input  logic         joypad_right,
  input  logic         joypad_a,
  input  logic         joypad_b,
  input  logic         joypad_select,
  input  logic         joypad_start,
  joypad_ctrl_if.slave p1,
  output logic [7:0]   keys_stable
);

  localparam int unsigned NKEYS = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NKEYS-1:0] raw;
  logic [NKEYS-1:0] sync1;
  logic [NKEYS-1:0] sync2;
  logic [NKEYS-1:0] stable;
  logic [CNT_W-1:0] cnt [NKEYS];
  logic [1:0]       sel;
  logic [3:0]       nib;
  logic [3:0]       prev_nibble;
  logic             irq;
  logic             unused_wdata;

  assign raw = {joypad_start, joypad_select, joypad_b, joypad_a,
                joypad_down, joypad_up, joypad_left, joypad_right};

  // Two-flop synchroniser followed by an independent debounce counter per key.
  always_ff @(posedge cpu_clk or negedge rst) begin
    if (!rst) begin
      sync1  <= '1;
      sync2  <= '1;
      stable <= '1;
      for (int i = 0; i < NKEYS; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < NKEYS; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge rst) begin
    if (!rst) begin
      sel <= 2'b11;
    end else if (p1.p1_wr) begin
      sel <= p1.p1_wdata[5:4];
    end
  end

  // A low select bit enables its group; both low ANDs the groups together.
  always_comb begin
    nib = 4'hF;
    case (sel)
      2'b10:   nib = stable[3:0];
      2'b01:   nib = stable[7:4];
      2'b00:   nib = stable[3:0] & stable[7:4];
      default: nib = 4'hF;
    endcase
  end

  // Any 1->0 on the visible nibble yields a single-cycle request.
  always_ff @(posedge cpu_clk or negedge rst) begin
    if (!rst) begin
      prev_nibble <= 4'hF;
      irq         <= 1'b0;
    end else begin
      prev_nibble <= nib;
      irq         <= |(prev_nibble & ~nib);
    end
  end

  assign p1.p1_rdata   = {2'b11, sel, nib};
  assign p1.irq_joypad = irq;
  assign keys_stable   = stable;
  assign unused_wdata  = ^{p1.p1_wdata[7:6], p1.p1_wdata[3:0]};

endmodule
